seven_seg_scanner: RTL and testbench

Time-multiplexed driver for the four-digit common-anode seven-segment display. Consumes the 1-cycle clk_en tick produced by the board's clock enabler (1 kHz from 100 MHz) and advances a digit-scan state machine on each tick. It drives active-low anodes, segments and decimal point. A frame-coherent snapshot of the 16-bit hex value prevents torn digits, and a per-digit blanking window suppresses ghosting.

---
 rtl/seven_seg_pkg.sv | 30 +++
 rtl/hex_to_seg.sv | 11 +
 rtl/seven_seg_scanner.sv | 114 +++++++++++
 tb/tb_seven_seg_scanner.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scanner. Display polarity is active-low throughout:
// a 0 on an anode selects that digit, a 0 on a segment or dp lights it.
package seven_seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  // Hex glyphs, {g,f,e,d,c,b,a}, indexed by nibble value (entry 15 is leftmost).
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,  // F E d C
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,  // b A 9 8
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,  // 7 6 5 4
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000   // 3 2 1 0
  };

  typedef enum logic {PhBlank, PhDrive} phase_e;

  // True when nibbles idx..3 of v are all zero; digit 0 is never a leading zero.
  function automatic logic lead_zero(logic [15:0] v, logic [1:0] idx);
    logic z;
    unique case (idx)
      2'd0:    z = 1'b0;
      2'd1:    z = (v[15:4] == 12'h000);
      2'd2:    z = (v[15:8] == 8'h00);
      default: z = (v[15:12] == 4'h0);
    endcase
    return z;
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment glyph.
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed display driver: per-digit slots of clk_en ticks, a leading blank window,
// and a shadow copy of the inputs taken only at frame end so a frame never shows torn digits.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int unsigned TICKS_PER_DIGIT = 4,
  parameter int unsigned BLANK_TICKS     = 1,
  parameter int unsigned LZ_BLANK        = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        clk_en,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int unsigned CntW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam logic [CntW-1:0] CntLast  = CntW'(TICKS_PER_DIGIT - 1);
  localparam logic [CntW-1:0] CntBlank = CntW'(BLANK_TICKS);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  logic [1:0]      idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     sh_value_q, sh_value_d;
  logic [3:0]      sh_dp_q, sh_dp_d;
  logic [3:0]      sh_en_q, sh_en_d;
  logic            frame_done_q, frame_done_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;

  phase_e     phase;
  logic [3:0] nibble;
  logic [6:0] glyph;
  logic       dark;

  always_ff @(posedge clk) begin
    if (clr) begin
      idx_q        <= 2'd0;
      cnt_q        <= '0;
      sh_value_q   <= 16'h0000;
      sh_dp_q      <= 4'h0;
      sh_en_q      <= 4'h0;
      frame_done_q <= 1'b0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
    end else begin
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      sh_value_q   <= sh_value_d;
      sh_dp_q      <= sh_dp_d;
      sh_en_q      <= sh_en_d;
      frame_done_q <= frame_done_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  always_comb begin
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    sh_value_d   = sh_value_q;
    sh_dp_d      = sh_dp_q;
    sh_en_d      = sh_en_q;
    frame_done_d = 1'b0;
    if (clk_en) begin
      if (cnt_q != CntLast) begin
        cnt_d = cnt_q + CntOne;
      end else begin
        cnt_d = '0;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          sh_value_d   = value;
          sh_dp_d      = dp_in;
          sh_en_d      = digit_en;
          frame_done_d = 1'b1;
        end
      end
    end
  end

  assign nibble = sh_value_q[{idx_q, 2'b00} +: 4];

  hex_to_seg u_hex_to_seg (
    .nibble (nibble),
    .seg    (glyph)
  );

  always_comb begin
    phase = ((BLANK_TICKS != 0) && (cnt_q < CntBlank)) ? PhBlank : PhDrive;
    dark  = !sh_en_q[idx_q] || ((LZ_BLANK != 0) && lead_zero(sh_value_q, idx_q));
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if ((phase == PhDrive) && !dark) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = glyph;
      dp_d  = ~sh_dp_q[idx_q];
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: a tick-count reference model checked every cycle, a table of
// display vectors, and hand-written sequences for mid-frame updates, mid-scan reset and free-run.
module tb_seven_seg_scanner;

  localparam int TPD   = 4;
  localparam int BLK   = 1;
  localparam int LZ    = 1;
  localparam int FRAME = 4 * TPD;
  localparam logic [11:0] DARK = 12'hFFF;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        clk_en = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  digit_en = 4'h0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .TICKS_PER_DIGIT (TPD),
    .BLANK_TICKS     (BLK),
    .LZ_BLANK        (LZ)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .clk_en     (clk_en),
    .value      (value),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  int total = 0;
  int bad = 0;

  // Reference model: ticks elapsed in the current frame plus the captured frame inputs.
  int          m_ticks = 0;
  logic [15:0] m_sv = 16'h0;
  logic [3:0]  m_sdp = 4'h0;
  logic [3:0]  m_sen = 4'h0;

  logic [11:0] drive_obs [4];
  logic [11:0] blank_obs [4];
  logic        fd_seen;

  typedef struct {
    logic [15:0]      value;
    logic [3:0]       dp_in;
    logic [3:0]       en;
    logic [3:0][11:0] want;
  } vec_t;

  function automatic logic [11:0] mk(logic [3:0] a, logic [6:0] s, logic d);
    return {a, s, d};
  endfunction

  function automatic logic [6:0] hex_ref(logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [11:0] model_disp();
    int slot = m_ticks / TPD;
    int cnt = m_ticks % TPD;
    logic [15:0] upper = m_sv >> (4 * slot);
    if (cnt < BLK || !m_sen[slot] || (LZ != 0 && slot > 0 && upper == 16'h0)) return DARK;
    return {4'hF & ~(4'b0001 << slot), hex_ref(upper[3:0]), ~m_sdp[slot]};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, want);
    end
  endtask

  // One clock: predict outputs from the pre-edge model, advance model, compare after the edge.
  task automatic step();
    logic [11:0] e;
    logic        efd;
    if (clr) begin
      e   = DARK;
      efd = 1'b0;
    end else begin
      e   = model_disp();
      efd = clk_en && (m_ticks == FRAME - 1);
    end
    @(posedge clk);
    if (clr) begin
      m_ticks = 0; m_sv = 16'h0; m_sdp = 4'h0; m_sen = 4'h0;
    end else if (clk_en) begin
      if (m_ticks == FRAME - 1) begin
        m_sv = value; m_sdp = dp_in; m_sen = digit_en;
      end
      m_ticks = (m_ticks + 1) % FRAME;
    end
    #1;
    check("scan", {3'b000, an, seg, dp, frame_done}, {3'b000, e, efd});
  endtask

  // One tick followed by idle cycles; records what the settled display shows for this slot.
  task automatic tick(input int gap);
    int slot;
    int cnt;
    clk_en = 1'b1;
    step();
    fd_seen = frame_done;
    clk_en = 1'b0;
    for (int i = 1; i < gap; i++) step();
    slot = m_ticks / TPD;
    cnt  = m_ticks % TPD;
    if (cnt == TPD - 1) drive_obs[slot] = {an, seg, dp};
    if (cnt == 0) blank_obs[slot] = {an, seg, dp};
  endtask

  task automatic clear_obs();
    for (int d = 0; d < 4; d++) begin
      drive_obs[d] = 12'h000;
      blank_obs[d] = 12'h000;
    end
  endtask

  task automatic align();
    for (int i = 0; i < FRAME && m_ticks != 0; i++) tick(3);
  endtask

  vec_t tv [7];
  int   n;
  int   pulses [$];

  initial begin
    tv[0] = '{16'h12AF, 4'b0010, 4'b1111, {mk(4'b0111, 7'b1111001, 1'b1),
              mk(4'b1011, 7'b0100100, 1'b1), mk(4'b1101, 7'b0001000, 1'b0),
              mk(4'b1110, 7'b0001110, 1'b1)}};
    tv[1] = '{16'h0070, 4'b0000, 4'b1111, {DARK, DARK,
              mk(4'b1101, 7'b1111000, 1'b1), mk(4'b1110, 7'b1000000, 1'b1)}};
    tv[2] = '{16'h0000, 4'b0000, 4'b1111, {DARK, DARK, DARK, mk(4'b1110, 7'b1000000, 1'b1)}};
    tv[3] = '{16'h8421, 4'b1111, 4'b1010, {mk(4'b0111, 7'b0000000, 1'b0), DARK,
              mk(4'b1101, 7'b0100100, 1'b0), DARK}};
    tv[4] = '{16'h0B0C, 4'b0100, 4'b1111, {DARK, mk(4'b1011, 7'b0000011, 1'b0),
              mk(4'b1101, 7'b1000000, 1'b1), mk(4'b1110, 7'b1000110, 1'b1)}};
    tv[5] = '{16'h3456, 4'b1111, 4'b0000, {DARK, DARK, DARK, DARK}};
    tv[6] = '{16'h0000, 4'b1111, 4'b1111, {DARK, DARK, DARK, mk(4'b1110, 7'b1000000, 1'b0)}};

    // Reset held with ticks present, then the first frame must be dark and end on tick 16.
    clr = 1'b1; clk_en = 1'b1;
    repeat (3) begin
      step();
      check("reset_out", {3'b000, an, seg, dp, frame_done}, {3'b000, DARK, 1'b0});
    end
    clr = 1'b0; clk_en = 1'b0;
    value = 16'h12AF; dp_in = 4'b0010; digit_en = 4'b1111;
    step();
    clear_obs();
    n = 0;
    fd_seen = 1'b0;
    while (!fd_seen && n < 40) begin
      tick(10);
      n++;
    end
    check("first_frame_len", 16'(n), 16'd16);
    for (int d = 0; d < 4; d++) check("first_frame_dark", {4'h0, drive_obs[d]}, {4'h0, DARK});

    // Table vectors: load shadow during one frame, observe it during the next.
    for (int i = 0; i < 7; i++) begin
      align();
      value = tv[i].value; dp_in = tv[i].dp_in; digit_en = tv[i].en;
      repeat (FRAME) tick(4);
      clear_obs();
      repeat (FRAME) tick(4);
      for (int d = 0; d < 4; d++) begin
        check($sformatf("vec%0d_drive%0d", i, d), {4'h0, drive_obs[d]}, {4'h0, tv[i].want[d]});
        check($sformatf("vec%0d_blank%0d", i, d), {4'h0, blank_obs[d]}, {4'h0, DARK});
      end
    end

    // Mid-frame update appears only in the following frame.
    value = 16'h1111; dp_in = 4'h0; digit_en = 4'hF;
    align();
    repeat (FRAME) tick(4);
    clear_obs();
    repeat (5) tick(4);
    value = 16'h2222;
    repeat (FRAME - 5) tick(4);
    for (int d = 0; d < 4; d++) check("midframe_old", {9'h0, drive_obs[d][7:1]}, 16'h0079);
    clear_obs();
    repeat (FRAME) tick(4);
    for (int d = 0; d < 4; d++) check("midframe_new", {9'h0, drive_obs[d][7:1]}, 16'h0024);

    // Reset coincident with a tick during digit 2 drive.
    align();
    repeat (2 * TPD + 1) tick(4);
    clr = 1'b1; clk_en = 1'b1;
    step();
    check("midscan_reset", {3'b000, an, seg, dp, frame_done}, {3'b000, DARK, 1'b0});
    clr = 1'b0; clk_en = 1'b0;
    step();
    clear_obs();
    n = 0;
    fd_seen = 1'b0;
    while (!fd_seen && n < 40) begin
      tick(4);
      n++;
    end
    check("restart_frame_len", 16'(n), 16'd16);
    for (int d = 0; d < 4; d++) check("restart_dark", {4'h0, drive_obs[d]}, {4'h0, DARK});

    // Continuous ticks: one-cycle frame_done every 16 cycles.
    clk_en = 1'b1;
    for (int c = 0; c < 4 * FRAME; c++) begin
      step();
      if (frame_done) pulses.push_back(c);
    end
    clk_en = 1'b0;
    check("free_run_pulses", 16'(pulses.size()), 16'd4);
    for (int i = 1; i < pulses.size(); i++)
      check("free_run_period", 16'(pulses[i] - pulses[i-1]), 16'(FRAME));

    // Random traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) begin
        value    = 16'($urandom);
        dp_in    = 4'($urandom);
        digit_en = 4'($urandom);
        if ($urandom_range(0, 1) == 0) value = value & 16'h00FF;
      end
      clk_en = ($urandom_range(0, 2) == 0);
      clr    = ($urandom_range(0, 299) == 0);
      step();
    end
    clr = 1'b0; clk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
